jpeg_cone_pipe: RTL
===================

// Module: jpeg_cone_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-bit five-input JPEG timing cone.
//  Evaluates the cone bitwise across LANES lanes: y = ((~c ^ b) | ~a) & d & ~e.
//  Each stage is elastic, with a valid/ready handshake, so the block sits between
//  stall-capable producers and consumers in the JPEG datapath.
//  An optional saturating hit counter tallies asserted output bits.
// PARAMETERS
//  LANES  4  number of independent cone lanes (>=1)
//  DEPTH  2  pipeline register stages (1..4); also the latency in cycles
//  CNT_W  16 width of the hit counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_a       in   LANES  cone input a (per lane)
//  in_b       in   LANES  cone input b
//  in_c       in   LANES  cone input c
//  in_d       in   LANES  cone input d
//  in_e       in   LANES  cone input e
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat
//  out_y      out  LANES  cone result
//  out_valid  out  1      out_y valid
//  out_ready  in   1      consumer accepts out_y
//  cnt_clr    in   1      synchronous clear of hit_cnt
//  hit_cnt    out  CNT_W  saturating count of 1-bits in accepted out_y
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids=0, out_valid=0, out_y=0, hit_cnt=0.
//    in_ready=1 during reset. A reset mid-operation drops all in-flight beats.
//  - Transfer: a beat moves when valid&ready are both high on a clk edge.
//    in_ready = ~v[0] | ready[0]; ready[k] = ~v[k+1] | ready[k+1]; last ready = out_ready.
//    The ready chain is combinational. There are no bubbles: full throughput is 1 beat/cycle.
//  - Latency: a beat accepted at edge t appears on out_y/out_valid after edge t+DEPTH-1.
//    DEPTH=1 gives one register.
//  - Split: stage 0 registers the partial term p = (~c ^ b) | ~a, plus d and ~e.
//    The final stage registers p & d & ~e. With DEPTH=1, the full cone is evaluated
//    before the single register. Extra stages (DEPTH>2) are pure delay.
//  - Stall: while out_valid & ~out_ready, out_y and out_valid hold stable.
//    Upstream stages fill, then in_ready falls.
//  - Data registers load only on transfer; valid bits clear on drain with no refill.
//  - Width rule: every operation is bitwise per lane; lanes never interact.
// CONFIGURATION
//  - JPEG_CONE_STATS_EN defined:
//    On each out_valid & out_ready edge, hit_cnt += popcount(out_y), saturating at 2^CNT_W-1.
//    cnt_clr has priority: clear and transfer on the same edge gives hit_cnt=0 (increment discarded).
//  - JPEG_CONE_STATS_EN not defined: hit_cnt is tied to 0, cnt_clr is ignored, and no counter logic exists.
// STRUCTURE
//  - Package jpeg_cone_pkg holds:
//    - function cone_eval(a,b,c,d,e) and function cone_partial(a,b,c)
//    - localparam MAX_DEPTH=4
//    - typedef lane vector type
//  - Sub-module jpeg_cone_stage: one elastic register stage with parameter W.
//    Ports: clk, rst_n, i_valid/i_ready/i_data, o_valid/o_ready/o_data.
//    It is instantiated DEPTH times via generate.
//  - Top level holds the cone logic between stages and the counter.
// TESTING
//  1. Reset mid-stream with 2 beats in flight -> out_valid=0, out_y=0, hit_cnt=0.
//     After release, no stale beat emerges.
//  2. LANES=4, DEPTH=2: a=1111,b=0000,c=0000,d=1111,e=0000 -> out_y=1111, two cycles after acceptance.
//     Then a=0101,b=0000,c=1111,d=1111,e=0011 -> out_y=1000.
//  3. Back-to-back 8 beats with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order.
//  4. Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0 and out_y stable.
//     Release -> beats drain in order with no loss or duplication.
//  5. STATS_EN, CNT_W=4: accept 5 beats of 1111 -> hit_cnt saturates at 15.
//     cnt_clr asserted on the same edge as a transfer -> hit_cnt=0.
//  6. STATS_EN undefined: same stimulus as 5 -> hit_cnt stays 0.
//     DEPTH=1 -> 1-cycle latency with the same results as 2.

Source files
------------

// File: rtl/jpeg_cone_pkg.sv
// Shared types and cone functions for the pipelined JPEG timing cone.
package jpeg_cone_pkg;

    localparam int unsigned MAX_DEPTH = 4;
    localparam int unsigned MAX_LANES = 64;

    typedef logic [MAX_LANES-1:0] lane_vec_t;

    // First half of the cone, registered in stage 0 when DEPTH > 1
    function automatic lane_vec_t cone_partial(input lane_vec_t a, input lane_vec_t b,
                                               input lane_vec_t c);
        return (~c ^ b) | ~a;
    endfunction

    // Full cone: y = ((~c ^ b) | ~a) & d & ~e
    function automatic lane_vec_t cone_eval(input lane_vec_t a, input lane_vec_t b,
                                            input lane_vec_t c, input lane_vec_t d,
                                            input lane_vec_t e);
        return cone_partial(a, b, c) & d & ~e;
    endfunction

endpackage

// File: rtl/jpeg_cone_stage.sv
// One elastic register stage: valid/ready handshake, combinational ready pass-through.
module jpeg_cone_stage
    import jpeg_cone_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [W-1:0] o_data
);

    assign i_ready = ~o_valid | o_ready;

    // Valid follows the upstream valid whenever the slot can move; data loads only on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (i_ready) begin
                o_valid <= i_valid;
            end
            if (i_valid && i_ready) begin
                o_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/jpeg_cone_pipe.sv
// Pipelined LANES-wide JPEG timing cone built from DEPTH elastic stages.
// Optional saturating hit counter enabled by defining JPEG_CONE_STATS_EN.
module jpeg_cone_pipe
    import jpeg_cone_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] in_a,
    input  logic [LANES-1:0] in_b,
    input  logic [LANES-1:0] in_c,
    input  logic [LANES-1:0] in_d,
    input  logic [LANES-1:0] in_e,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LANES-1:0] out_y,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int unsigned PW = 3 * LANES;

    if (DEPTH == 1) begin : g_single
        logic [LANES-1:0] y_next;

        assign y_next = LANES'(cone_eval(lane_vec_t'(in_a), lane_vec_t'(in_b), lane_vec_t'(in_c),
                                         lane_vec_t'(in_d), lane_vec_t'(in_e)));

        jpeg_cone_stage #(.W(LANES)) u_final (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (in_valid),
            .i_ready (in_ready),
            .i_data  (y_next),
            .o_valid (out_valid),
            .o_ready (out_ready),
            .o_data  (out_y)
        );
    end else begin : g_multi
        // Element k is the input side of stage k; element 0 is the block input
        logic          sv [DEPTH];
        logic          sr [DEPTH];
        logic [PW-1:0] sd [DEPTH];
        logic [PW-1:0] tail;
        logic [LANES-1:0] y_next;

        assign sv[0]    = in_valid;
        assign in_ready = sr[0];
        assign sd[0]    = {LANES'(cone_partial(lane_vec_t'(in_a), lane_vec_t'(in_b),
                                               lane_vec_t'(in_c))), in_d, ~in_e};

        for (genvar k = 0; k < DEPTH - 1; k++) begin : g_mid
            jpeg_cone_stage #(.W(PW)) u_mid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (sv[k]),
                .i_ready (sr[k]),
                .i_data  (sd[k]),
                .o_valid (sv[k+1]),
                .o_ready (sr[k+1]),
                .o_data  (sd[k+1])
            );
        end

        // Finish the cone from the carried {p, d, ~e} triple
        assign tail   = sd[DEPTH-1];
        assign y_next = tail[3*LANES-1:2*LANES] & tail[2*LANES-1:LANES] & tail[LANES-1:0];

        jpeg_cone_stage #(.W(LANES)) u_final (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (sv[DEPTH-1]),
            .i_ready (sr[DEPTH-1]),
            .i_data  (y_next),
            .o_valid (out_valid),
            .o_ready (out_ready),
            .o_data  (out_y)
        );
    end

`ifdef JPEG_CONE_STATS_EN
    localparam int unsigned SUM_W = CNT_W + LANES;

    logic [SUM_W-1:0] pop_y;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] hit_q;

    // Popcount of the output beat and the unsaturated running sum
    always_comb begin
        pop_y = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            pop_y = pop_y + SUM_W'(out_y[i]);
        end
        sum = SUM_W'(hit_q) + pop_y;
    end

    // Saturating tally of accepted 1-bits; clear wins over a same-edge transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else if (cnt_clr) begin
            hit_q <= '0;
        end else if (out_valid && out_ready) begin
            hit_q <= (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
        end
    end

    assign hit_cnt = hit_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
`endif

endmodule
